// File: rtl/par2ser_pkg.sv
// Shared types and constants for the DDR parallel-to-serial block:
// state encoding, PRBS7 polynomial/seed and TMDS control words.
package par2ser_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // x^7 + x^6 + 1, Fibonacci form, new bit enters at bit 0
  localparam int         PRBS7_TAP_A = 6;
  localparam int         PRBS7_TAP_B = 5;
  localparam logic [6:0] PRBS7_SEED  = 7'h7F;

  // TMDS control-period words, indexed by {c1,c0}
  localparam logic [3:0][9:0] TMDS_CTRL = {
    10'b1010101011,  // 11
    10'b0101010100,  // 10
    10'b0010101011,  // 01
    10'b1101010100   // 00
  };

  function automatic logic [6:0] prbs7_step(input logic [6:0] s);
    return {s[5:0], s[PRBS7_TAP_A] ^ s[PRBS7_TAP_B]};
  endfunction

endpackage

// File: rtl/par2ser_prbs7.sv
// Parallel PRBS7 generator: presents the next WORD_W sequence bits (LSB first)
// and advances WORD_W steps whenever a word is taken.
module par2ser_prbs7
  import par2ser_pkg::*;
#(
  parameter int WORD_W = 10
) (
  input  logic              clk,
  input  logic              sclr,
  input  logic              advance,
  output logic [WORD_W-1:0] word
);

  logic [6:0] lfsr;
  logic [6:0] lfsr_nxt;

  // NOTE: blocking assignments here are intentional -- each loop pass must see
  // the state produced by the previous pass; always_ff blocks use <= only.
  always_comb begin
    lfsr_nxt = lfsr;
    word     = '0;
    for (int i = 0; i < WORD_W; i++) begin
      lfsr_nxt = prbs7_step(lfsr_nxt);
      word[i]  = lfsr_nxt[0];
    end
  end

  always_ff @(posedge clk) begin
    if (sclr)         lfsr <= PRBS7_SEED;
    else if (advance) lfsr <= lfsr_nxt;
  end

endmodule

// File: rtl/par2ser_ddr_serializer.sv
// Multi-channel word serializer for the TMDS DDR output path, 2 bits per clk.
// Optional PRBS7 test pattern enabled by defining PAR2SER_PRBS_EN.
module par2ser_ddr_serializer
  import par2ser_pkg::*;
#(
  parameter int                NUM_CH    = 4,
  parameter int                WORD_W    = 10,
  parameter logic [WORD_W-1:0] IDLE_WORD = WORD_W'(TMDS_CTRL[0])
) (
  input  logic                     clk,
  input  logic                     sclr,
  input  logic                     oe,
  input  logic [NUM_CH*WORD_W-1:0] in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     test_en,
  output logic [NUM_CH-1:0]        dout_h,
  output logic [NUM_CH-1:0]        dout_l,
  output logic                     oe_out,
  output logic                     underrun,
  output logic                     underrun_stk
);

  localparam int            HALF   = WORD_W / 2;
  localparam int            KW     = (HALF > 1) ? $clog2(HALF) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(HALF - 1);

  typedef logic [NUM_CH-1:0][WORD_W-1:0] lanes_t;

  state_t        state;
  logic [KW-1:0] k;
  lanes_t        sh;
  lanes_t        hold;
  logic          hold_full;
  lanes_t        base_word;
  lanes_t        load_word;
  logic          at_boundary;
  logic          load_evt;
  logic          word_load;
  logic          accept;

  assign at_boundary = (state == RUN) && (k == K_LAST);
  // load_evt: hold is consumed this edge; word_load also covers IDLE_WORD fills
  assign load_evt    = oe && hold_full && ((state == IDLE) || at_boundary);
  assign word_load   = load_evt || (oe && at_boundary);
  assign in_ready    = !hold_full || load_evt;
  assign accept      = in_valid && in_ready;
  assign base_word   = hold_full ? hold : {NUM_CH{IDLE_WORD}};
  assign oe_out      = (state == RUN);

`ifdef PAR2SER_PRBS_EN
  logic [WORD_W-1:0] prbs_word;

  par2ser_prbs7 #(.WORD_W(WORD_W)) u_prbs (
    .clk     (clk),
    .sclr    (sclr),
    .advance (word_load && test_en),
    .word    (prbs_word)
  );

  assign load_word = test_en ? {NUM_CH{prbs_word}} : base_word;
`else
  logic unused_test_en;
  assign unused_test_en = test_en;
  assign load_word      = base_word;
`endif

  // Output pins are straight taps of the shift-register flops
  always_comb begin
    dout_h = '0;
    dout_l = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      dout_h[c] = sh[c][0];
      dout_l[c] = sh[c][1];
    end
  end

  // NOTE: hold data is not reset; hold_full alone says whether it is meaningful,
  // so clearing the wide data register would only cost reset fan-out.
  always_ff @(posedge clk) begin
    if (accept) hold <= in_data;
  end

  always_ff @(posedge clk) begin
    if (sclr) begin
      state        <= IDLE;
      k            <= '0;
      sh           <= '0;
      hold_full    <= 1'b0;
      underrun     <= 1'b0;
      underrun_stk <= 1'b0;
    end else begin
      underrun <= 1'b0;
      if (accept)        hold_full <= 1'b1;
      else if (load_evt) hold_full <= 1'b0;

      case (state)
        IDLE: begin
          sh <= '0;
          if (oe && hold_full) begin
            sh    <= load_word;
            k     <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          if (k != K_LAST) begin
            for (int c = 0; c < NUM_CH; c++) sh[c] <= sh[c] >> 2;
            k <= k + KW'(1);
          end else if (!oe) begin
            sh    <= '0;
            k     <= '0;
            state <= IDLE;
          end else begin
            sh <= load_word;
            k  <= '0;
            if (!hold_full) begin
              underrun     <= 1'b1;
              underrun_stk <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
